// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive packer: receiver FSM state
// encoding, default parameter values and a small sizing helper.
package uart_pkg;

    // Receiver FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int CLOCKS_PER_PULSE_DEF = 10;
    localparam int BITS_PER_WORD_DEF    = 8;
    localparam int N_WORDS_DEF          = 4;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_bit.sv
// UART bit-level receiver: 2-flop synchronizer, start/data/parity/stop FSM,
// bit timer and LSB-first shift register. Emits one-cycle word_valid,
// frame_err and parity_err strobes in the cycle the deciding bit is sampled.
// Optional feature macro: UART_PARITY_EN (adds an even-parity bit after data).
module uart_rx_bit
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = CLOCKS_PER_PULSE_DEF,
    parameter int BITS_PER_WORD    = BITS_PER_WORD_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx,
    output logic [BITS_PER_WORD-1:0] word,
    output logic                     word_valid,
    output logic                     frame_err,
    output logic                     parity_err,
    output logic                     busy
);

    localparam int TMR_W = cnt_width(CLOCKS_PER_PULSE);
    localparam int BIT_W = cnt_width(BITS_PER_WORD);
    localparam logic [TMR_W-1:0] TMR_FULL = TMR_W'(CLOCKS_PER_PULSE - 1);
    localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_PER_WORD - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

`ifdef UART_PARITY_EN
    localparam uart_state_t ST_AFTER_DATA = ST_PARITY;

    // High when data plus received parity bit do not have an even number of ones
    function automatic logic parity_bad(input logic [BITS_PER_WORD-1:0] data, input logic par);
        return (^data) ^ par;
    endfunction
`else
    localparam uart_state_t ST_AFTER_DATA = ST_STOP;
`endif

    logic [1:0]               rx_sync_q, rx_sync_d;
    logic                     rx_s;
    uart_state_t              state_q, state_d;
    logic [TMR_W-1:0]         tmr_q, tmr_d;
    logic [BIT_W-1:0]         bit_q, bit_d;
    logic [BITS_PER_WORD-1:0] shift_q, shift_d;
    logic                     stop_wait_q, stop_wait_d;
    logic                     par_bad_q, par_bad_d;
    logic                     busy_q, busy_d;

    assign rx_s = rx_sync_q[1];
    assign word = shift_q;
    assign busy = busy_q;

    // Synchronizer input shift: rx enters bit 0, rx_s leaves bit 1
    always_comb begin
        rx_sync_d = {rx_sync_q[0], rx};
    end

    // State, timer, synchronizer and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync_q   <= 2'b11;
            state_q     <= ST_IDLE;
            tmr_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            stop_wait_q <= 1'b0;
            par_bad_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_sync_q   <= rx_sync_d;
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            stop_wait_q <= stop_wait_d;
            par_bad_q   <= par_bad_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and bit-timing logic; every sample point is a timer wrap
    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        stop_wait_d = stop_wait_q;
        par_bad_d   = par_bad_q;
        case (state_q)
            ST_IDLE: begin
                tmr_d       = '0;
                bit_d       = '0;
                stop_wait_d = 1'b0;
                par_bad_d   = 1'b0;
                if (rx_s == 1'b0) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                // Mid start bit: a high line here means it was only a glitch
                if (tmr_q == TMR_HALF) begin
                    tmr_d = '0;
                    if (rx_s == 1'b0) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_ONE;
                end
            end
            ST_DATA: begin
                if (tmr_q == TMR_FULL) begin
                    tmr_d   = '0;
                    shift_d = {rx_s, shift_q[BITS_PER_WORD-1:1]};
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = ST_AFTER_DATA;
                    end else begin
                        bit_d   = bit_q + BIT_ONE;
                        state_d = ST_DATA;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_ONE;
                end
            end
            ST_PARITY: begin
`ifdef UART_PARITY_EN
                if (tmr_q == TMR_FULL) begin
                    tmr_d     = '0;
                    par_bad_d = parity_bad(shift_q, rx_s);
                    state_d   = ST_STOP;
                end else begin
                    tmr_d   = tmr_q + TMR_ONE;
                    state_d = ST_PARITY;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_STOP: begin
                // After a bad stop bit, hold here until the line idles high
                if (stop_wait_q) begin
                    if (rx_s == 1'b1) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_STOP;
                    end
                end else if (tmr_q == TMR_FULL) begin
                    tmr_d = '0;
                    if (rx_s == 1'b1) begin
                        state_d = ST_IDLE;
                    end else begin
                        stop_wait_d = 1'b1;
                        state_d     = ST_STOP;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Event strobes decoded at the stop / parity sample points
    always_comb begin
        word_valid = 1'b0;
        frame_err  = 1'b0;
        parity_err = 1'b0;
        busy_d     = (state_d != ST_IDLE);
        case (state_q)
            ST_PARITY: begin
`ifdef UART_PARITY_EN
                if (tmr_q == TMR_FULL) begin
                    parity_err = parity_bad(shift_q, rx_s);
                end else begin
                    parity_err = 1'b0;
                end
`else
                parity_err = 1'b0;
`endif
            end
            ST_STOP: begin
                if (!stop_wait_q && (tmr_q == TMR_FULL)) begin
                    if (rx_s == 1'b1) begin
                        // A word that already failed parity is silently dropped
                        word_valid = !par_bad_q;
                    end else begin
                        frame_err = 1'b1;
                    end
                end else begin
                    word_valid = 1'b0;
                end
            end
            default: begin
                word_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/uart_rx_packer.sv
// UART receive packer: collects N_WORDS received words into one bus, first
// word in the least significant slot, and presents it through a single
// valid/ready output register. A bus completing while the register is still
// full is dropped and flagged with an overflow pulse.
// Optional feature macro: UART_PARITY_EN (even parity checked per word).
module uart_rx_packer
    import uart_pkg::*;
#(
    parameter int  CLOCKS_PER_PULSE = CLOCKS_PER_PULSE_DEF,
    parameter int  BITS_PER_WORD    = BITS_PER_WORD_DEF,
    parameter int  N_WORDS          = N_WORDS_DEF,
    localparam int W_BUS            = N_WORDS * BITS_PER_WORD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    output logic [W_BUS-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             frame_err,
    output logic             parity_err,
    output logic             overflow,
    output logic             busy
);

    localparam int CNT_W = cnt_width(N_WORDS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [BITS_PER_WORD-1:0] word_s;
    logic                     word_valid_s;
    logic                     frame_err_s;
    logic                     parity_err_s;
    logic                     bus_done_s;

    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [W_BUS-1:0] pack_q, pack_d;
    logic [W_BUS-1:0] m_data_q, m_data_d;
    logic             m_valid_q, m_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             parity_err_q, parity_err_d;
    logic             overflow_q, overflow_d;

    uart_rx_bit #(
        .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE),
        .BITS_PER_WORD   (BITS_PER_WORD)
    ) u_rx_bit (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .word      (word_s),
        .word_valid(word_valid_s),
        .frame_err (frame_err_s),
        .parity_err(parity_err_s),
        .busy      (busy)
    );

    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overflow   = overflow_q;

    // Word slot counter and packing buffer; a bad word restarts the bus
    always_comb begin
        word_cnt_d = word_cnt_q;
        pack_d     = pack_q;
        bus_done_s = 1'b0;
        if (word_valid_s) begin
            pack_d[int'(word_cnt_q) * BITS_PER_WORD +: BITS_PER_WORD] = word_s;
            if (word_cnt_q == CNT_LAST) begin
                word_cnt_d = '0;
                bus_done_s = 1'b1;
            end else begin
                word_cnt_d = word_cnt_q + CNT_ONE;
            end
        end else if (frame_err_s || parity_err_s) begin
            word_cnt_d = '0;
        end else begin
            word_cnt_d = word_cnt_q;
        end
    end

    // Output register: load when free (or draining this cycle), else drop and flag
    always_comb begin
        m_data_d     = m_data_q;
        m_valid_d    = m_valid_q;
        overflow_d   = 1'b0;
        frame_err_d  = frame_err_s;
        parity_err_d = parity_err_s;
        if (bus_done_s) begin
            if (!m_valid_q || m_ready) begin
                m_data_d  = pack_d;
                m_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end else begin
            m_valid_d = m_valid_q;
        end
    end

    // Packer and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_q   <= '0;
            pack_q       <= '0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            word_cnt_q   <= word_cnt_d;
            pack_q       <= pack_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overflow_q   <= overflow_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_packer.sv
// Self-checking bench for uart_rx_packer. Frames are driven bit by bit on rx;
// when a frame is issued, a word-list model decides the resulting bus and
// pushes it into a scoreboard queue. A monitor pops and compares on every
// output handshake and counts error pulses. Honours UART_PARITY_EN.
module tb_uart_rx_packer;

    localparam int CPP = 10;
    localparam int BPW = 8;
    localparam int NW  = 4;
    localparam int W   = NW * BPW;

    logic         clk     = 1'b0;
    logic         rst     = 1'b1;
    logic         rx      = 1'b1;
    logic         m_ready = 1'b1;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         frame_err;
    logic         parity_err;
    logic         overflow;
    logic         busy;

    always #5 clk = ~clk;

    uart_rx_packer #(
        .CLOCKS_PER_PULSE(CPP),
        .BITS_PER_WORD   (BPW),
        .N_WORDS         (NW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overflow  (overflow),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard and reference model state
    logic [W-1:0]   exp_q[$];
    logic [BPW-1:0] acc[$];
    bit             out_full    = 1'b0;
    logic [W-1:0]   model_mdata = '0;
    int exp_frame = 0, exp_parity = 0, exp_overflow = 0;
    int got_frame = 0, got_parity = 0, got_overflow = 0;
    logic prev_fe = 1'b0, prev_pe = 1'b0, prev_ov = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: accepted words accumulate; N of them form a bus, first word lowest
    task automatic model_word(input logic [BPW-1:0] w, input bit good);
        logic [W-1:0] bus;
        if (!good) begin
            acc.delete();
        end else begin
            acc.push_back(w);
            if (acc.size() == NW) begin
                bus = '0;
                for (int i = 0; i < NW; i++)
                    bus = bus | ({{(W-BPW){1'b0}}, acc[i]} << (BPW * i));
                acc.delete();
                if (!out_full || m_ready) begin
                    exp_q.push_back(bus);
                    model_mdata = bus;
                    out_full    = !m_ready;
                end else begin
                    exp_overflow++;
                end
            end
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPP) @(negedge clk);
    endtask

    task automatic send_frame(input logic [BPW-1:0] w, input bit stop_ok, input bit par_ok);
        model_word(w, stop_ok && par_ok);
        if (!stop_ok) exp_frame++;
        if (!par_ok) exp_parity++;
        drive_bit(1'b0);
        for (int i = 0; i < BPW; i++) drive_bit(w[i]);
`ifdef UART_PARITY_EN
        drive_bit((^w) ^ (par_ok ? 1'b0 : 1'b1));
`endif
        if (stop_ok) begin
            drive_bit(1'b1);
        end else begin
            drive_bit(1'b0);
            drive_bit(1'b0);
            drive_bit(1'b0);
            drive_bit(1'b1);
        end
    endtask

    task automatic glitch();
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        check("glitch_busy_high", busy, 1);
        repeat (CPP) @(negedge clk);
        check("glitch_busy_low", busy, 0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_parity_err"}, parity_err, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_frame_cnt"}, got_frame, exp_frame);
        check({tag, "_parity_cnt"}, got_parity, exp_parity);
        check({tag, "_overflow_cnt"}, got_overflow, exp_overflow);
        check({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    // Monitor: scoreboard pop on handshake, error pulse accounting
    always @(negedge clk) begin
        logic [W-1:0] exp_bus;
        #1;
        if (!rst) begin
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got m_data=%0h, expected no bus", m_data);
                end else begin
                    exp_bus = exp_q.pop_front();
                    check("m_data", m_data, exp_bus);
                end
            end
            if (frame_err)  got_frame++;
            if (parity_err) got_parity++;
            if (overflow)   got_overflow++;
            if (frame_err || parity_err || overflow)
                check("pulse_exclusive", 64'(frame_err) + 64'(parity_err) + 64'(overflow), 1);
            if (prev_fe) check("frame_err_single", frame_err, 0);
            if (prev_pe) check("parity_err_single", parity_err, 0);
            if (prev_ov) check("overflow_single", overflow, 0);
        end
        prev_fe = frame_err;
        prev_pe = parity_err;
        prev_ov = overflow;
    end

    initial begin
        logic [BPW-1:0] w;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic bus
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        send_frame(8'h33, 1'b1, 1'b1);
        send_frame(8'h44, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        check("basic_m_data", m_data, 64'h44332211);
        check_counts("basic");

        // Start-bit glitch between words must not count a word
        send_frame(8'h5A, 1'b1, 1'b1);
        glitch();
        send_frame(8'h6B, 1'b1, 1'b1);
        send_frame(8'h7C, 1'b1, 1'b1);
        send_frame(8'h8D, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        check_counts("glitch");

        // Bad stop bit on the second word restarts the bus
        send_frame(8'h55, 1'b1, 1'b1);
        send_frame(8'h66, 1'b0, 1'b1);
        for (int i = 0; i < NW; i++) send_frame(8'hA0 + 8'(i), 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        check("frame_m_data", m_data, 64'hA3A2A1A0);
        check_counts("frame");

        // Random words, gaps and glitches
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < NW; k++) begin
                if ($urandom_range(0, 3) == 0) glitch();
                send_frame(8'($urandom), 1'b1, 1'b1);
                repeat ($urandom_range(0, 6)) @(negedge clk);
            end
        end
        repeat (5) @(negedge clk);
        check_counts("random");

        // Backpressure: second bus overflows, first is held then drained
        m_ready = 1'b0;
        for (int k = 0; k < 2 * NW; k++) send_frame(8'($urandom), 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        check("ovf_m_valid_held", m_valid, 1);
        check("ovf_m_data_held", m_data, model_mdata);
        check("ovf_count", got_overflow, exp_overflow);
        m_ready  = 1'b1;
        out_full = 1'b0;
        repeat (3) @(negedge clk);
        check("drain_m_valid", m_valid, 0);
        check("drain_m_data_hold", m_data, model_mdata);
        check_counts("drain");

`ifdef UART_PARITY_EN
        // Parity error clears the word counter
        send_frame(8'h21, 1'b1, 1'b1);
        send_frame(8'h03, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("parity_cnt", got_parity, exp_parity);
        send_frame(8'h03, 1'b1, 1'b1);
        send_frame(8'h10, 1'b1, 1'b1);
        send_frame(8'h20, 1'b1, 1'b1);
        send_frame(8'h30, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        check("parity_m_data", m_data, 64'h30201003);
        check_counts("parity");
`endif

        // Reset in the middle of the third word
        send_frame(8'hB1, 1'b1, 1'b1);
        send_frame(8'hB2, 1'b1, 1'b1);
        w = 8'hB3;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(w[i]);
        check("mid_busy_before_reset", busy, 1);
        check("mid_sb_empty", exp_q.size(), 0);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        check_cleared("mid_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        acc.delete();
        out_full = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 1; i <= NW; i++) send_frame(8'(i), 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        check("post_reset_m_data", m_data, 64'h04030201);

        // Bounded drain of anything still expected
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        check_counts("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_packer.md
UART_RX_PACKER -- requirements
Module: uart_rx_packer

Interface
REQ-001 SHALL have parameter CLOCKS_PER_PULSE, default 10, meaning clk cycles per UART bit (even, >=4).
REQ-002 SHALL have parameter BITS_PER_WORD, default 8, meaning data bits per UART word, sent LSB first.
REQ-003 SHALL have parameter N_WORDS, default 4, meaning words packed per output bus; the bus width W_BUS is N_WORDS*BITS_PER_WORD.
REQ-004 SHALL have port clk, input, width 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, width 1: synchronous, active-high reset.
REQ-006 SHALL have port rx, input, width 1: asynchronous serial line, idle high.
REQ-007 SHALL have port m_data, output, width W_BUS: the packed words, first received word in bits [BITS_PER_WORD-1:0].
REQ-008 SHALL have port m_valid, output, width 1, and port m_ready, input, width 1: output handshake.
REQ-009 SHALL have ports frame_err, parity_err, overflow and busy, all outputs of width 1.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer (rx_s); all sampling below refers to rx_s.
REQ-011 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP.
- IDLE->START on rx_s==0.
- START: resample rx_s CLOCKS_PER_PULSE/2 cycles after entry; 1 = glitch, return to IDLE with nothing recorded; 0 = go to DATA.
REQ-012 SHALL, in DATA, sample one bit every CLOCKS_PER_PULSE cycles, BITS_PER_WORD times, shifting in LSB first; it then goes to PARITY if UART_PARITY_EN is defined, otherwise to STOP.
REQ-013 SHALL, in STOP, sample rx_s CLOCKS_PER_PULSE cycles after the previous sample.
- rx_s==1: the word is accepted; the word counter increments.
- rx_s==0: frame_err pulses high for 1 cycle, the word is discarded, the word counter is cleared to 0, and the FSM stays in STOP until rx_s==1.
REQ-014 SHALL then return to IDLE, after which a new start bit is accepted.
REQ-015 SHALL, on accepting word N_WORDS-1, wrap the word counter to 0 and offer the assembled bus to the output register.
REQ-016 SHALL, when the output register is free (m_valid==0, or m_valid&&m_ready in the same cycle), load m_data and assert m_valid on the cycle after the stop sample; simultaneous drain and load keeps m_valid high with the new data.
REQ-017 SHALL, when a bus completes while m_valid&&!m_ready, pulse overflow for 1 cycle and drop the new bus, leaving m_data and m_valid unchanged.
REQ-018 SHALL clear m_valid on the cycle after m_valid&&m_ready with no new load; m_data is held.
REQ-019 SHALL drive busy high whenever the state is not IDLE.
REQ-020 SHALL keep frame_err, parity_err and overflow as single-cycle pulses, never asserted together.

Reset
REQ-021 SHALL, on rst, set state=IDLE, word counter=0, m_data=0, m_valid=0, frame_err=parity_err=overflow=busy=0, and synchronizer flops=1.
REQ-022 SHALL, on rst mid-word or mid-bus, discard the partial data; the first complete frame after reset is received correctly.

Configuration
REQ-023 SHALL, with macro UART_PARITY_EN defined, expect one even-parity bit after the data bits.
- The PARITY state samples it CLOCKS_PER_PULSE cycles after the last data bit.
- On mismatch it pulses parity_err, discards the word and clears the word counter, then goes to STOP.
REQ-024 SHALL, without UART_PARITY_EN, omit the PARITY state, expect no parity bit, and tie parity_err to 0.

Structure
REQ-025 SHALL place the FSM state enum typedef and the default parameter constants in the shared package uart_pkg.
REQ-026 SHALL use a sub-module uart_rx_bit containing the synchronizer, FSM, bit counter and shift register, emitting word/word_valid plus the error pulses; uart_rx_packer holds the word counter, packing and output register.

Verification (CLOCKS_PER_PULSE=10, BITS_PER_WORD=8, N_WORDS=4)
REQ-027 SHALL cover: words 0x11,0x22,0x33,0x44 with m_ready=1 -> one m_valid pulse with m_data=0x44332211, no error pulses.
REQ-028 SHALL cover: rx low for 3 cycles then high -> no word counted, busy returns to 0, no error pulses.
REQ-029 SHALL cover: 2nd word sent with stop bit 0 -> frame_err pulse; a following 4 good words 0xA0..0xA3 -> m_data=0xA3A2A1A0.
REQ-030 SHALL cover: m_ready=0 while two buses are sent -> first bus held in m_data, overflow pulses once at the end of the second; m_ready=1 -> first bus drained, m_valid=0.
REQ-031 SHALL cover: rst asserted mid-DATA of word 3 -> all outputs 0; then 4 words 0x01..0x04 -> m_data=0x04030201.
REQ-032 SHALL cover, with UART_PARITY_EN: word 0x03 sent with parity bit 1 -> parity_err pulse, counter cleared; correct parity -> word accepted.
